// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer handlers (write and read side).
// Gray/binary conversion is done on a fixed wide pointer type; callers
// zero-extend their (WIDTH+1)-bit pointer in and truncate the result back.
// Zero-extension is harmless for both conversions because the upper zero
// bits contribute nothing to the lower bits of either result.
package fifo_pkg;

  localparam int unsigned FIFO_AW   = 3;
  localparam int unsigned DEPTH     = 2 ** FIFO_AW;
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB downwards.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
      b[PTR_MAX_W-1-i] = b[PTR_MAX_W-i] ^ g[PTR_MAX_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_handler.sv
// Write-side pointer and flag logic of the async FIFO (write clock domain).
// Ports:
//   clk, rst        write clock, async active-high reset
//   w_en            producer write request
//   g_rptr_sync     Gray read pointer already synchronized into clk domain
//   ovf_clr         clears the sticky overflow flag
//   wr_fire         write accepted this cycle (RAM write enable)
//   waddr           RAM write address
//   b_wptr, g_wptr  binary / Gray write pointers (g_wptr feeds read-side sync)
//   full            registered full flag
//   almost_full     registered, wr_level >= AF_THRESH
//   wr_level        conservative occupancy seen from the write domain
//   overflow        sticky: write attempted while full
// WIDTH+1 must not exceed fifo_pkg::PTR_MAX_W.
module fifo_wptr_handler
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [WIDTH:0]   g_rptr_sync,
  input  logic             ovf_clr,
  output logic             wr_fire,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH:0]   b_wptr,
  output logic [WIDTH:0]   g_wptr,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH:0]   wr_level,
  output logic             overflow
);

  localparam int unsigned    PW   = WIDTH + 1;
  localparam logic [WIDTH:0] AF_T = PW'(AF_THRESH);

  logic [WIDTH:0] b_wptr_q, b_wptr_d;
  logic [WIDTH:0] g_wptr_q, g_wptr_d;
  logic [WIDTH:0] wr_level_q, wr_level_d;
  logic           full_q, full_d;
  logic           almost_full_q, almost_full_d;
  logic           overflow_q, overflow_d;
  logic [WIDTH:0] rbin;

  always_comb begin
    wr_fire       = w_en & ~full_q;
    b_wptr_d      = b_wptr_q + {{WIDTH{1'b0}}, wr_fire};
    // Gray pointer comes from the next binary value, not from b_wptr_q,
    // so the registered Gray output changes exactly one bit per step.
    g_wptr_d      = PW'(bin2gray(ptr_t'(b_wptr_d)));
    rbin          = PW'(gray2bin(ptr_t'(g_rptr_sync)));
    wr_level_d    = b_wptr_d - rbin;
    // Full: write pointer is one lap ahead, i.e. the two MSBs of the Gray
    // read pointer inverted and the rest equal.
    full_d        = (g_wptr_d == {~g_rptr_sync[WIDTH:WIDTH-1], g_rptr_sync[WIDTH-2:0]});
    almost_full_d = (wr_level_d >= AF_T);
    // Set dominates clear.
    overflow_d    = (w_en & full_q) | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_wptr_q      <= '0;
      g_wptr_q      <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      b_wptr_q      <= b_wptr_d;
      g_wptr_q      <= g_wptr_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign waddr       = b_wptr_q[WIDTH-1:0];
  assign b_wptr      = b_wptr_q;
  assign g_wptr      = g_wptr_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;

endmodule
